// File: rtl/bnn_interface_gen_if.sv
// ---------------------------------------------------------------------------
// bnn_interface_gen_if
// Core-side bundle between bnn_interface_gen and the BNN inference core.
//   core_img    : repacked image, channel c at [c*IMG_W*IMG_W +: IMG_W*IMG_W]
//   core_start  : one-cycle launch pulse
//   core_abort  : one-cycle abort pulse
//   core_done   : core result valid (single-cycle pulse)
//   core_result : core class index
// Modports: master = interface block, slave = inference core.
// ---------------------------------------------------------------------------
interface bnn_interface_gen_if #(
    parameter int unsigned IMG_W = 30,
    parameter int unsigned IC    = 1,
    parameter int unsigned RES_W = 4
) ();
    localparam int unsigned IMG_BITS = IC * IMG_W * IMG_W;

    logic [IMG_BITS-1:0] core_img;
    logic                core_start;
    logic                core_abort;
    logic                core_done;
    logic [RES_W-1:0]    core_result;

    modport master (
        output core_img,
        output core_start,
        output core_abort,
        input  core_done,
        input  core_result
    );

    modport slave (
        input  core_img,
        input  core_start,
        input  core_abort,
        output core_done,
        output core_result
    );
endinterface

// File: rtl/bnn_interface_gen.sv
// ---------------------------------------------------------------------------
// bnn_interface_gen
// Control/data bridge between the image buffer and the BNN inference core.
// Captures a padded image word, drops the low pad bits, launches the core
// with a one-cycle start pulse, supervises completion with a timeout and
// holds a range-checked class result until the host clears it.
//
// Ports:
//   i_clk             : clock, rising edge
//   i_rst_n           : synchronous active-low reset
//   i_img_in          : padded image, pixels in MSBs, pad in [PAD_BITS-1:0]
//   i_img_buffer_full : image buffer holds a complete image
//   i_bnn_enable      : host permits an inference
//   i_bnn_clear       : host acknowledge / abort
//   core_if           : core-side bundle (master modport)
//   o_result_out      : held class result
//   o_result_ready    : o_result_out is valid
//   o_timeout_err     : core did not answer within TIMEOUT_CYCLES
//   o_class_err       : last captured core_result was out of range
//   o_busy            : inference in flight (LAUNCH or WAIT)
//   o_infer_count     : saturating count of completed captures
// All outputs are registered.
// ---------------------------------------------------------------------------
module bnn_interface_gen #(
    parameter int unsigned IMG_W          = 30,
    parameter int unsigned IC             = 1,
    parameter int unsigned PAD_BITS       = 4,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned RES_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [IC*IMG_W*IMG_W+PAD_BITS-1:0]  i_img_in,
    input  logic                                i_img_buffer_full,
    input  logic                                i_bnn_enable,
    input  logic                                i_bnn_clear,
    bnn_interface_gen_if.master                 core_if,
    output logic [RES_W-1:0]                    o_result_out,
    output logic                                o_result_ready,
    output logic                                o_timeout_err,
    output logic                                o_class_err,
    output logic                                o_busy,
    output logic [COUNT_W-1:0]                  o_infer_count
);

    localparam int unsigned IMG_BITS = IC * IMG_W * IMG_W;
    localparam int unsigned IN_BITS  = IMG_BITS + PAD_BITS;
    localparam int unsigned TIMER_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    // One extra bit so the compare stays correct when NUM_CLASSES == 2**RES_W.
    localparam logic [RES_W:0]     CLASS_LIMIT = (RES_W + 1)'(NUM_CLASSES);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StDone,
        StError
    } state_e;

    state_e               r_state,        w_state_next;
    logic [IMG_BITS-1:0]  r_core_img,     w_core_img_next;
    logic                 r_core_start,   w_core_start_next;
    logic                 r_core_abort,   w_core_abort_next;
    logic [RES_W-1:0]     r_result,       w_result_next;
    logic                 r_ready,        w_ready_next;
    logic                 r_timeout_err,  w_timeout_err_next;
    logic                 r_class_err,    w_class_err_next;
    logic                 r_busy,         w_busy_next;
    logic [COUNT_W-1:0]   r_count,        w_count_next;
    logic [TIMER_W-1:0]   r_timer,        w_timer_next;

    logic                 w_class_oor;
    logic                 w_capture;

    assign w_class_oor = ({1'b0, core_if.core_result} >= CLASS_LIMIT);
    assign w_capture   = i_img_buffer_full && i_bnn_enable;

    // Next-state and next-output logic.
    always_comb begin
        w_state_next       = r_state;
        w_core_img_next    = r_core_img;
        w_core_abort_next  = 1'b0;
        w_result_next      = r_result;
        w_ready_next       = r_ready;
        w_timeout_err_next = r_timeout_err;
        w_class_err_next   = r_class_err;
        w_count_next       = r_count;
        w_timer_next       = r_timer;

        case (r_state)
            StIdle: begin
                w_ready_next = 1'b0;
                if (w_capture) begin
                    w_core_img_next = i_img_in[IN_BITS-1:PAD_BITS];
                    w_state_next    = StLaunch;
                end
            end

            StLaunch: begin
                w_timer_next = '0;
                if (i_bnn_clear) begin
                    w_core_abort_next = 1'b1;
                    w_state_next      = StIdle;
                end else begin
                    w_state_next = StWait;
                end
            end

            StWait: begin
                w_timer_next = r_timer + 1'b1;
                // Priority: host abort, then core completion, then timeout.
                if (i_bnn_clear) begin
                    w_core_abort_next = 1'b1;
                    w_state_next      = StIdle;
                end else if (core_if.core_done) begin
                    w_result_next    = w_class_oor ? '0 : core_if.core_result;
                    w_class_err_next = w_class_oor;
                    w_ready_next     = 1'b1;
                    if (r_count != {COUNT_W{1'b1}}) begin
                        w_count_next = r_count + 1'b1;
                    end
                    w_state_next = StDone;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout_err_next = 1'b1;
                    w_core_abort_next  = 1'b1;
                    w_state_next       = StError;
                end
            end

            StDone: begin
                if (i_bnn_clear) begin
                    w_ready_next = 1'b0;
                    w_state_next = StIdle;
                end
            end

            StError: begin
                if (i_bnn_clear) begin
                    w_timeout_err_next = 1'b0;
                    w_state_next       = StIdle;
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Start is high exactly while the FSM sits in LAUNCH.
        w_core_start_next = (w_state_next == StLaunch);
        w_busy_next       = (w_state_next == StLaunch) || (w_state_next == StWait);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_core_img    <= '0;
            r_core_start  <= 1'b0;
            r_core_abort  <= 1'b0;
            r_result      <= '0;
            r_ready       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_class_err   <= 1'b0;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_timer       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_core_img    <= w_core_img_next;
            r_core_start  <= w_core_start_next;
            r_core_abort  <= w_core_abort_next;
            r_result      <= w_result_next;
            r_ready       <= w_ready_next;
            r_timeout_err <= w_timeout_err_next;
            r_class_err   <= w_class_err_next;
            r_busy        <= w_busy_next;
            r_count       <= w_count_next;
            r_timer       <= w_timer_next;
        end
    end

    assign core_if.core_img   = r_core_img;
    assign core_if.core_start = r_core_start;
    assign core_if.core_abort = r_core_abort;

    assign o_result_out   = r_result;
    assign o_result_ready = r_ready;
    assign o_timeout_err  = r_timeout_err;
    assign o_class_err    = r_class_err;
    assign o_busy         = r_busy;
    assign o_infer_count  = r_count;

endmodule

// File: doc/bnn_interface_gen.md
Name: bnn_interface_gen

Overview:
Parametrised control/data interface between the image buffer and the BNN inference core. It captures a padded image word, strips the pad bits and repacks the remainder into channels. It launches the core with a one-cycle start pulse and supervises completion with a timeout. It holds a validated class result until the host clears it, adding abort, timeout, class-range checking and an inference counter.

Parameters:
IMG_W, 30, image side length in pixels
IC, 1, input channel count
PAD_BITS, 4, low-order pad bits on img_in, discarded
NUM_CLASSES, 10, number of legal class indices (0..NUM_CLASSES-1)
RES_W, 4, result width; must satisfy 2**RES_W >= NUM_CLASSES
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before a timeout is declared
COUNT_W, 16, width of the completed-inference counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset: synchronous, active-low
img_in  in  IC*IMG_W*IMG_W+PAD_BITS  padded image; pixels in the MSBs, pad bits in [PAD_BITS-1:0]
img_buffer_full  in  1  image buffer holds a complete image
bnn_enable  in  1  host permits an inference
bnn_clear  in  1  host acknowledge / abort
core_img  out  IC*IMG_W*IMG_W  registered image; channel c occupies [c*IMG_W*IMG_W +: IMG_W*IMG_W]
core_start  out  1  one-cycle launch pulse to the core
core_abort  out  1  one-cycle abort pulse to the core
core_done  in  1  core result valid (single-cycle pulse)
core_result  in  RES_W  core class index
result_out  out  RES_W  held class result
result_ready  out  1  result_out is valid
timeout_err  out  1  core did not respond within TIMEOUT_CYCLES
class_err  out  1  last core_result was >= NUM_CLASSES
busy  out  1  high in LAUNCH or WAIT
infer_count  out  COUNT_W  count of successful captures, saturating

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, core_img=0, result_out=0, result_ready=0, timeout_err=0, class_err=0, core_start=0, core_abort=0, infer_count=0, timer=0. Reset mid-inference discards everything; no abort pulse is issued.
- States: IDLE, LAUNCH, WAIT, DONE, ERROR. All outputs are registered.
- IDLE: on img_buffer_full && bnn_enable, load core_img <= img_in[MSB:PAD_BITS] and go to LAUNCH. result_ready=0.
- LAUNCH: core_start=1 for exactly this one cycle (asserted in the cycle following the capture edge). timer cleared. Next state is WAIT.
- WAIT: timer increments every cycle.
  - core_done=1: result_out <= core_result, result_ready <= 1 on the next edge, state -> DONE, infer_count++ (saturates at 2**COUNT_W-1).
  - If core_result >= NUM_CLASSES on that capture: result_out <= 0 and class_err <= 1; otherwise class_err <= 0. The counter increments either way.
  - timer == TIMEOUT_CYCLES-1 without core_done: timeout_err <= 1, state -> ERROR, core_abort pulses for one cycle.
  - core_done on the final timeout cycle: done wins and no timeout is raised.
- Latency: launch edge to result_ready = core latency + 1 cycle.
- bnn_clear in LAUNCH or WAIT: abort. core_abort pulses for one cycle, state -> IDLE, nothing captured, counter unchanged. bnn_clear beats a simultaneous core_done.
- DONE: result_ready and result_out are held. bnn_clear -> IDLE, result_ready <= 0, result_out retained.
- ERROR: timeout_err is held. bnn_clear -> IDLE and clears timeout_err.
- A core_done arriving outside WAIT is ignored.
- bnn_enable dropping after launch has no effect. A new capture needs IDLE with both img_buffer_full and bnn_enable high.

Test Plan:
- Reset, then img_in with MSB pixel=1 and pad=4'hF; full=enable=1; core_done after 5 cycles with result 7 -> core_img[899]=1, pad dropped, core_start is one cycle wide, result_ready high 6 cycles after the launch edge, result_out=7, infer_count=1.
- In DONE, hold bnn_clear low for 20 cycles, then pulse it -> result_ready stays 1 for all 20 cycles, drops 1 cycle after the clear, state=IDLE, result_out stays 7.
- Never assert core_done -> after 1024 WAIT cycles timeout_err=1 and core_abort pulses once; bnn_clear -> timeout_err=0; infer_count unchanged.
- core_result=12 -> result_out=0, class_err=1, result_ready=1, infer_count increments.
- bnn_clear and core_done in the same WAIT cycle -> state=IDLE, result_ready=0, core_abort pulses, infer_count unchanged.
- Reset asserted mid-WAIT -> all outputs return to reset values on the next edge; with IC=2, IMG_W=4, PAD_BITS=0, channel 1 is img_in[31:16].
